// File: rtl/alu.sv
// ALU: unsigned 16-bit add / subtract / multiply / divide with registered result.
//
// Ports:
//   clk      in   1   single clock, all state updates on rising edge
//   rst_n    in   1   synchronous active-low reset, aborts any running operation
//   start    in   1   launch request, accepted only while idle
//   num1     in   16  first operand, unsigned, [0:15] with bit 0 = MSB
//   num2     in   16  second operand, same format as num1
//   op       in   2   0 add, 1 subtract, 2 multiply, 3 divide
//   res      out  16  registered result, [0:15] with bit 0 = MSB
//   isValid  out  1   res holds a completed, error-free result
//   err      out  1   last completed operation failed (res forced to zero)
//   busy     out  1   multi-cycle operation in progress
//
// Add and subtract complete one edge after acceptance. Multiply (shift-add) and
// divide (restoring) run 16 iterations and complete 17 edges after acceptance.
//
// Configuration macro ALU_DIV_EN: when defined the divider is built; otherwise
// op=3 completes one edge after acceptance with err=1.

module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [0:15] num1,
   input  logic [0:15] num2,
   input  logic [1:0]  op,
   output logic [0:15] res,
   output logic        isValid,
   output logic        err,
   output logic        busy
);

   localparam logic [1:0] OpAdd = 2'd0;
   localparam logic [1:0] OpSub = 2'd1;
   localparam logic [1:0] OpMul = 2'd2;
   localparam logic [1:0] OpDiv = 2'd3;

   localparam logic [4:0] NumIter = 5'd16;

   typedef enum logic [0:0] {StIdle, StCalc} state_e;

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   // Multiply: a = multiplicand, b = multiplier shifted out MSB first.
   // Divide:   a = dividend shifted out MSB first / quotient shifted in, b = divisor.
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   // Multiply: product accumulator. Divide: low half holds the partial remainder.
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] res_q, res_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [16:0] sum;
   logic [16:0] diff;
   logic        fin;
   logic [15:0] fin_res;
   logic        fin_err;

`ifdef ALU_DIV_EN
   logic [16:0] rem_sh;
   logic [16:0] trial;
`endif

   // Bit 16 of sum is the carry out; bit 16 of diff is the borrow (num1 < num2).
   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {1'b0, a_q} - {1'b0, b_q};

`ifdef ALU_DIV_EN
   assign rem_sh = {acc_q[15:0], a_q[15]};
   assign trial  = rem_sh - {1'b0, b_q};
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      valid_d = valid_q;
      err_d   = err_q;
      fin     = 1'b0;
      fin_res = 16'h0000;
      fin_err = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCalc;
               op_d    = op;
               a_d     = num1;
               b_d     = num2;
               acc_d   = 32'h0;
               cnt_d   = 5'd0;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end
         end

         StCalc: begin
            unique case (op_q)
               OpAdd: begin
                  fin     = 1'b1;
                  fin_res = sum[15:0];
                  fin_err = sum[16];
               end

               OpSub: begin
                  fin     = 1'b1;
                  fin_res = diff[15:0];
                  fin_err = diff[16];
               end

               OpMul: begin
                  if (cnt_q == NumIter) begin
                     fin     = 1'b1;
                     fin_res = acc_q[15:0];
                     fin_err = |acc_q[31:16];
                  end else begin
                     acc_d = {acc_q[30:0], 1'b0} + (b_q[15] ? {16'h0, a_q} : 32'h0);
                     b_d   = {b_q[14:0], 1'b0};
                     cnt_d = cnt_q + 5'd1;
                  end
               end

               OpDiv: begin
`ifdef ALU_DIV_EN
                  if (b_q == 16'h0000) begin
                     fin     = 1'b1;
                     fin_err = 1'b1;
                  end else if (cnt_q == NumIter) begin
                     fin     = 1'b1;
                     fin_res = a_q;
                  end else begin
                     // Restoring step: keep the trial remainder only if it did not borrow.
                     if (!trial[16]) begin
                        acc_d[15:0] = trial[15:0];
                        a_d         = {a_q[14:0], 1'b1};
                     end else begin
                        acc_d[15:0] = rem_sh[15:0];
                        a_d         = {a_q[14:0], 1'b0};
                     end
                     cnt_d = cnt_q + 5'd1;
                  end
`else
                  fin     = 1'b1;
                  fin_err = 1'b1;
`endif
               end

               default: begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end
            endcase

            if (fin) begin
               state_d = StIdle;
               res_d   = fin_err ? 16'h0000 : fin_res;
               valid_d = !fin_err;
               err_d   = fin_err;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= 2'd0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         acc_q   <= 32'h0;
         cnt_q   <= 5'd0;
         res_q   <= 16'h0000;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Busy rises one edge after acceptance (first iteration done) and drops at completion.
   assign busy    = (state_q == StCalc) && (cnt_q != 5'd0);
   assign res     = res_q;
   assign isValid = valid_q;
   assign err     = err_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: driver pushes expected responses into a scoreboard
// queue, a monitor pops and compares whenever a completion appears on the outputs.

module tb_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [0:15] num1 = 16'h0;
   logic [0:15] num2 = 16'h0;
   logic [1:0]  op = 2'd0;
   logic [0:15] res;
   logic        isValid;
   logic        err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .num1    (num1),
      .num2    (num2),
      .op      (op),
      .res     (res),
      .isValid (isValid),
      .err     (err),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     op;
      int     a;
      int     b;
      int     res;
      int     valid;
      int     err;
      int     lat;
      int     busy_cyc;
      longint t_acc;
   } exp_t;

   exp_t sbq[$];

   // Reference model: plain integer arithmetic from the operation rules.
   function automatic exp_t model(input int o, input int a, input int b);
      exp_t        e;
      longint      x = a;
      longint      y = b;
      longint      r = 0;
      bit          bad = 1'b0;
      int          lat = 1;
      case (o)
         0: begin r = x + y; bad = (r > 65535); end
         1: begin if (x < y) bad = 1'b1; else r = x - y; end
         2: begin r = x * y; bad = (r > 65535); lat = 17; end
         default: begin
`ifdef ALU_DIV_EN
            if (y == 0) bad = 1'b1;
            else begin r = x / y; lat = 17; end
`else
            bad = 1'b1;
`endif
         end
      endcase
      e.op       = o;
      e.a        = a;
      e.b        = b;
      e.res      = bad ? 0 : int'(r);
      e.valid    = bad ? 0 : 1;
      e.err      = bad ? 1 : 0;
      e.lat      = lat;
      e.busy_cyc = lat - 1;
      e.t_acc    = 0;
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a completion is the rising of isValid|err (both are cleared on acceptance).
   initial begin
      bit   prev_done = 1'b0;
      bit   done;
      int   busy_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            done = isValid | err;
            if (done && !prev_done) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_completion: got res=%0d isValid=%0b err=%0b expected none",
                           res, isValid, err);
               end else begin
                  e = sbq.pop_front();
                  $display("op=%0d a=%0d b=%0d -> res=%0d v=%0b e=%0b", e.op, e.a, e.b, res,
                           isValid, err);
                  chk("res", res, e.res);
                  chk("isValid", isValid, e.valid);
                  chk("err", err, e.err);
                  chk("exclusive", isValid & err, 0);
                  chk("latency", ($time - 5 - e.t_acc) / 10, e.lat);
                  chk("busy_cycles", busy_cnt, e.busy_cyc);
                  chk("busy_at_done", busy, 0);
               end
               busy_cnt = 0;
            end
            prev_done = done;
         end
      end
   end

   // Called away from a rising edge; start is sampled on the next rising edge.
   task automatic issue(input int o, input int a, input int b);
      exp_t e;
      num1  = 16'(a);
      num2  = 16'(b);
      op    = 2'(o);
      start = 1'b1;
      @(posedge clk);
      e       = model(o, a, b);
      e.t_acc = $time;
      sbq.push_back(e);
      #1;
      start = 1'b0;
      // Scramble inputs to show the running operation ignores them.
      num1  = 16'($urandom);
      num2  = 16'($urandom);
      op    = 2'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending after %0d cycles expected 0", sbq.size(), n);
         sbq.delete();
      end
   endtask

   task automatic run(input int o, input int a, input int b);
      issue(o, a, b);
      wait_done();
   endtask

   initial begin
      int o;
      int a;
      int b;

      // Reset with start held: nothing may be accepted while rst_n=0.
      rst_n = 1'b0;
      start = 1'b1;
      num1  = 16'd5;
      num2  = 16'd1;
      op    = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_res", res, 0);
      chk("reset_isValid", isValid, 0);
      chk("reset_err", err, 0);
      chk("reset_busy", busy, 0);

      // First edge with rst_n=1 accepts: 5+1 = 6.
      rst_n = 1'b1;
      run(0, 5, 1);

      // Directed cases, issued back-to-back.
      run(1, 3, 5);
      run(2, 300, 200);
      run(2, 300, 300);
      run(2, 250, 200);
      run(3, 100, 7);
      run(3, 100, 0);
      run(0, 0, 0);
      run(2, 0, 1234);
      run(3, 0, 9);
      run(0, 65535, 1);
      run(0, 65534, 1);
      run(1, 5, 5);
      run(2, 255, 257);
      run(2, 256, 256);
      run(3, 65535, 1);
      run(3, 7, 100);

      // Second start during a busy multiply is ignored.
      issue(2, 250, 200);
      repeat (5) @(negedge clk);
      #1;
      num1  = 16'd1;
      num2  = 16'd1;
      op    = 2'd0;
      start = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      start = 1'b0;
      wait_done();

      // Reset in the middle of a multiply aborts it.
      issue(2, 300, 200);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      sbq.delete();
      chk("abort_res", res, 0);
      chk("abort_busy", busy, 0);
      chk("abort_isValid", isValid, 0);
      chk("abort_err", err, 0);
      rst_n = 1'b1;
      #1;
      run(0, 7, 8);

      // Randomized operations with random idle gaps.
      for (int i = 0; i < 60; i++) begin
         o = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
         end else begin
            a = int'($urandom_range(0, 300));
            b = int'($urandom_range(0, 300));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         #1;
         run(o, a, b);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before 300000");
      $fatal(1);
   end

endmodule
